// File: rtl/vga_scroll_ctrl.sv
// Frame-synchronous scroll offset scheduler with pause/step buttons.
// Define VGA_SCROLL_DEBOUNCE_EN to enable the button debounce filter.
module vga_scroll_ctrl #(
  parameter int H_TOTAL         = 800,
  parameter int V_TOTAL         = 525,
  parameter int FRAMES_PER_STEP = 64,
  parameter int STEP_SIZE       = 10,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hcount_in,
  input  logic [9:0] vcount_in,
  input  logic       btn_pause_in,
  input  logic       btn_step_in,
  input  logic       dir_in,
  output logic [9:0] scroll_offset_out,
  output logic       frame_tick_out,
  output logic       paused_out
);

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_PAUSED = 1'b1;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [7:0] FC_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [9:0] STEP    = 10'(STEP_SIZE);

  if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 256 ||
      STEP_SIZE < 0 || STEP_SIZE > 1023 ||
      DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("vga_scroll_ctrl: illegal parameter value");
  end

  logic       eof;
  logic [1:0] btn_raw;
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] lvl;
  logic [1:0] lvl_q;
  logic [1:0] press;

  logic       state;
  logic [7:0] frame_cnt;
  logic       pause_pend;
  logic       step_pend;
  logic [9:0] offset;
  logic       tick;
  logic [9:0] step_val;

  assign eof = (hcount_in == H_LAST) && (vcount_in == V_LAST);

  // bit 0 = pause button, bit 1 = step button
  assign btn_raw = {btn_step_in, btn_pause_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

`ifdef VGA_SCROLL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0][DB_W-1:0] db_cnt;

  // level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl    <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl[i]    <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign lvl = sync_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign press = lvl & ~lvl_q;

  // eof consumes every set flag; a press in the eof cycle survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_pend <= 1'b0;
      step_pend  <= 1'b0;
    end else begin
      pause_pend <= (pause_pend & ~eof) | press[0];
      step_pend  <= (step_pend & ~eof) |
                    (press[1] & (state == ST_PAUSED));
    end
  end

  assign step_val = dir_in ? (offset - STEP) : (offset + STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      frame_cnt <= '0;
      offset    <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= eof;
      if (eof) begin
        unique case (state)
          ST_RUN: begin
            if (pause_pend) begin
              state <= ST_PAUSED;
            end else if (frame_cnt == FC_LAST) begin
              frame_cnt <= '0;
              offset    <= step_val;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          ST_PAUSED: begin
            if (pause_pend) begin
              state <= ST_RUN;
            end else if (step_pend) begin
              offset <= step_val;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

  assign scroll_offset_out = offset;
  assign frame_tick_out    = tick;
  assign paused_out        = (state == ST_PAUSED);

endmodule

// File: tb/tb_vga_scroll_ctrl.sv
// Randomized bench for vga_scroll_ctrl against a frame-level model.
// Honours VGA_SCROLL_DEBOUNCE_EN for the short-pulse expectation.
module tb_vga_scroll_ctrl;

  localparam int H    = 20;
  localparam int V    = 10;
  localparam int FPS  = 4;
  localparam int STEP = 10;
  localparam int DB   = 16;
  localparam int FCYC = H * V;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       btn_pause;
  logic       btn_step;
  logic       dir;
  logic [9:0] scroll_offset;
  logic       frame_tick;
  logic       paused;

  vga_scroll_ctrl #(
    .H_TOTAL(H),
    .V_TOTAL(V),
    .FRAMES_PER_STEP(FPS),
    .STEP_SIZE(STEP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hcount_in(hcount),
    .vcount_in(vcount),
    .btn_pause_in(btn_pause),
    .btn_step_in(btn_step),
    .dir_in(dir),
    .scroll_offset_out(scroll_offset),
    .frame_tick_out(frame_tick),
    .paused_out(paused)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // frame-level model
  int m_off;
  int m_fc;
  bit m_paused;
  bit m_pp;
  bit m_sp;
  bit m_tick;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("offset", 32'(scroll_offset), 32'(m_off));
      check("paused", 32'(paused), 32'(m_paused));
      check("tick", 32'(frame_tick), 32'(m_tick));
    end
  end

  function automatic int wrap(int x);
    return ((x % 1024) + 1024) % 1024;
  endfunction

  task automatic model_reset();
    m_off = 0;
    m_fc = 0;
    m_paused = 0;
    m_pp = 0;
    m_sp = 0;
    m_tick = 0;
  endtask

  task automatic model_eof();
    int delta;
    delta = dir ? -STEP : STEP;
    if (!m_paused) begin
      if (m_pp) begin
        m_paused = 1;
      end else begin
        m_fc = m_fc + 1;
        if (m_fc == FPS) begin
          m_fc = 0;
          m_off = wrap(m_off + delta);
        end
      end
    end else begin
      if (m_pp) m_paused = 0;
      else if (m_sp) m_off = wrap(m_off + delta);
    end
    m_pp = 0;
    m_sp = 0;
  endtask

  task automatic tick_cycle(int hc, int vc, bit is_eof);
    hcount = 10'(hc);
    vcount = 10'(vc);
    @(posedge clk);
    #1;
    if (is_eof) begin
      model_eof();
      m_tick = 1;
    end else begin
      m_tick = 0;
    end
  endtask

  // act: 0 idle, 1 pause, 2 step, 3 double step, 4 pause+step, 5 short pause pulse
  task automatic run_frame(int act, bit do_rst);
    bit ins;
    ins = ($urandom_range(0, 3) == 0);
    if (act == 1 || act == 4) m_pp = 1;
`ifndef VGA_SCROLL_DEBOUNCE_EN
    if (act == 5) m_pp = 1;
`endif
    if (act >= 2 && act <= 4 && m_paused) m_sp = 1;
    for (int i = 0; i < FCYC; i++) begin
      btn_pause = ((act == 1 || act == 4) && i >= 10 && i < 50) ||
                  (act == 5 && i >= 10 && i < 20);
      btn_step  = (act >= 2 && act <= 4 && i >= 10 && i < 50) ||
                  (act == 3 && i >= 80 && i < 120);
      if (ins && i == 150) begin
        tick_cycle(1023, 5, 0);
        tick_cycle(H - 1, V, 0);
      end
      if (do_rst && i == 153) rst_n = 1;
      if (do_rst && i == 150) begin
        check("pre_rst_paused", 32'(paused), 32'd1);
        hcount = 10'(i % H);
        vcount = 10'(i / H);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("rst_offset", 32'(scroll_offset), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        @(posedge clk);
        #1;
        m_tick = 0;
      end else begin
        tick_cycle(i % H, i / H, i == FCYC - 1);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    hcount = '0;
    vcount = '0;
    btn_pause = 0;
    btn_step = 0;
    dir = 0;
    model_reset();
    @(posedge clk);
    #1;
    chk_en = 1;
    check("reset_offset", 32'(scroll_offset), 32'd0);
    check("reset_paused", 32'(paused), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    for (int f = 0; f < 24; f++) begin
      dir = (f >= 11);
      run_frame(0, 0);
      if (f + 1 == 3) check("lit_f3", 32'(scroll_offset), 32'd0);
      if (f + 1 == 4) check("lit_f4", 32'(scroll_offset), 32'd10);
      if (f + 1 == 8) check("lit_f8", 32'(scroll_offset), 32'd20);
      if (f + 1 == 20) check("lit_wrap", 32'(scroll_offset), 32'd1014);
    end

    dir = 0;
    run_frame(1, 0);
    check("lit_pause", 32'(paused), 32'd1);
    check("lit_pause_off", 32'(scroll_offset), 32'd1004);
    for (int f = 0; f < 8; f++) run_frame(0, 0);
    check("lit_hold", 32'(scroll_offset), 32'd1004);
    run_frame(3, 0);
    check("lit_dstep", 32'(scroll_offset), 32'd1014);
    run_frame(4, 0);
    check("lit_both_p", 32'(paused), 32'd0);
    check("lit_both_o", 32'(scroll_offset), 32'd1014);
    run_frame(5, 0);
`ifdef VGA_SCROLL_DEBOUNCE_EN
    check("lit_glitch", 32'(paused), 32'd0);
`else
    check("lit_glitch", 32'(paused), 32'd1);
`endif
    if (!m_paused) run_frame(1, 0);
    else run_frame(0, 0);
    check("lit_repause", 32'(paused), 32'd1);
    run_frame(2, 1);
    check("lit_post_rst_o", 32'(scroll_offset), 32'd0);
    check("lit_post_rst_p", 32'(paused), 32'd0);
    run_frame(0, 0);
    run_frame(0, 0);
    check("lit_no_step", 32'(scroll_offset), 32'd0);
    run_frame(0, 0);
    check("lit_first_step", 32'(scroll_offset), 32'd10);

    for (int f = 0; f < 150; f++) begin
      int r;
      dir = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      run_frame((r < 5) ? 0 : r - 4, 0);
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
